// File: rtl/mips_muldiv_pkg.sv
// Shared encodings and helpers for the MIPS multiply/divide unit.
// Operation codes match the op port; FSM states are plain constants for legacy tools.
package mips_muldiv_pkg;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;
    localparam logic [2:0] OP_MADD  = 3'd6;
    localparam logic [2:0] OP_MSUB  = 3'd7;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_FIN  = 2'd2;

    // Wide enough for a 2*WIDTH product with WIDTH up to 64; callers size-cast in and out.
    localparam int MAG_W = 128;

    // Two's-complement magnitude / sign restore: negate when neg is set, pass through otherwise.
    function automatic logic [MAG_W-1:0] cond_negate(input logic [MAG_W-1:0] value,
                                                     input logic             neg);
        return neg ? -value : value;
    endfunction

endpackage

// File: rtl/mips_muldiv_core.sv
// Per-cycle datapath: one shared 2*WIDTH shift register does shift-add multiply
// ({upper accumulator, multiplier}) or restoring divide ({remainder, quotient}).
module mips_muldiv_core
    import mips_muldiv_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             load,
    input  logic             step,
    input  logic             fin,
    input  logic             is_div,
    input  logic [WIDTH-1:0] a_mag,
    input  logic [WIDTH-1:0] b_mag,
    output logic [WIDTH-1:0] acc_hi,
    output logic [WIDTH-1:0] acc_lo,
    output logic             last_step
);

    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   opnd;
    logic               div_mode;
    logic [CNT_W-1:0]   count;

    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     shifted;
    logic               div_ge;
    logic [WIDTH-1:0]   div_rem;
    logic [2*WIDTH-1:0] next_acc;

    assign acc_hi    = acc[2*WIDTH-1:WIDTH];
    assign acc_lo    = acc[WIDTH-1:0];
    assign last_step = (count == CNT_W'(WIDTH - 1));

    // Multiply adds the multiplicand when the multiplier LSB is set, then shifts right;
    // divide shifts the next dividend bit into the remainder and subtracts if it fits.
    always_comb begin
        mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
        shifted  = acc[2*WIDTH-1:WIDTH-1];
        div_ge   = (shifted >= {1'b0, opnd});
        div_rem  = div_ge ? WIDTH'(shifted - {1'b0, opnd}) : shifted[WIDTH-1:0];
        next_acc = div_mode ? {div_rem, acc[WIDTH-2:0], div_ge}
                            : {mul_sum, acc[WIDTH-1:1]};
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            acc      <= '0;
            opnd     <= '0;
            div_mode <= 1'b0;
            count    <= '0;
        end else if (load) begin
            acc      <= {{WIDTH{1'b0}}, (is_div ? a_mag : b_mag)};
            opnd     <= is_div ? b_mag : a_mag;
            div_mode <= is_div;
            count    <= '0;
        end else if (step) begin
            acc      <= next_acc;
            count    <= count + CNT_W'(1);
        end else if (fin) begin
            count    <= '0;
        end
    end

endmodule

// File: rtl/mips_muldiv_unit.sv
// Iterative MIPS MULT/MULTU/DIV/DIVU unit with HI/LO registers and MTHI/MTLO.
// Define MIPS_MULDIV_MADD_EN to enable MADD/MSUB accumulation into {hi,lo}.
module mips_muldiv_unit
    import mips_muldiv_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic             illegal,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int PW = 2 * WIDTH;

    logic [1:0]       state;
    logic [2:0]       op_q;
    logic             sign_a;
    logic             sign_b;
    logic             div0;

    logic             accept_arith;
    logic             op_signed;
    logic             op_div;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;

    logic             core_load;
    logic [WIDTH-1:0] acc_hi;
    logic [WIDTH-1:0] acc_lo;
    logic             last_step;

    logic [PW-1:0]    prod_signed;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] rem;
    logic [PW-1:0]    result;

    assign busy      = (state != ST_IDLE);
    assign core_load = (state == ST_IDLE) && start && accept_arith;

    // Decode the requested op and strip signs so the core only sees magnitudes.
    always_comb begin
        accept_arith = (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
`ifdef MIPS_MULDIV_MADD_EN
        accept_arith = accept_arith || (op == OP_MADD) || (op == OP_MSUB);
`endif
        op_signed = (op == OP_MULT) || (op == OP_DIV) || (op == OP_MADD) || (op == OP_MSUB);
        op_div    = (op == OP_DIV) || (op == OP_DIVU);
        a_neg     = op_signed && A[WIDTH-1];
        b_neg     = op_signed && B[WIDTH-1];
        a_mag     = WIDTH'(cond_negate(MAG_W'(A), a_neg));
        b_mag     = WIDTH'(cond_negate(MAG_W'(B), b_neg));
    end

    mips_muldiv_core #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_core (
        .CLK       (CLK),
        .RESET     (RESET),
        .load      (core_load),
        .step      (state == ST_RUN),
        .fin       (state == ST_FIN),
        .is_div    (op_div),
        .a_mag     (a_mag),
        .b_mag     (b_mag),
        .acc_hi    (acc_hi),
        .acc_lo    (acc_lo),
        .last_step (last_step)
    );

    // Sign correction: quotient negative when signs differ, remainder follows the dividend.
    // A zero divisor leaves the dividend in the remainder path; only the quotient is forced.
    always_comb begin
        prod_signed = PW'(cond_negate(MAG_W'({acc_hi, acc_lo}), sign_a ^ sign_b));
        quo         = div0 ? {WIDTH{1'b1}} : WIDTH'(cond_negate(MAG_W'(acc_lo), sign_a ^ sign_b));
        rem         = WIDTH'(cond_negate(MAG_W'(acc_hi), sign_a));
        case (op_q)
            OP_DIV, OP_DIVU: result = {rem, quo};
`ifdef MIPS_MULDIV_MADD_EN
            OP_MADD:         result = {hi, lo} + prod_signed;
            OP_MSUB:         result = {hi, lo} - prod_signed;
`endif
            default:         result = prod_signed;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state   <= ST_IDLE;
            op_q    <= '0;
            sign_a  <= 1'b0;
            sign_b  <= 1'b0;
            div0    <= 1'b0;
            hi      <= '0;
            lo      <= '0;
            done    <= 1'b0;
            illegal <= 1'b0;
        end else begin
            done    <= 1'b0;
            illegal <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        if (accept_arith) begin
                            state  <= ST_RUN;
                            op_q   <= op;
                            sign_a <= a_neg;
                            sign_b <= b_neg;
                            div0   <= op_div && (B == '0);
                        end else if (op == OP_MTHI) begin
                            hi   <= A;
                            done <= 1'b1;
                        end else if (op == OP_MTLO) begin
                            lo   <= A;
                            done <= 1'b1;
                        end else begin
                            illegal <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (last_step) begin
                        state <= ST_FIN;
                    end
                end
                ST_FIN: begin
                    hi    <= result[PW-1:WIDTH];
                    lo    <= result[WIDTH-1:0];
                    done  <= 1'b1;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
